coin_acceptor: RTL

- Front-end stage that feeds the vending-machine FSM its `money` code.
- Conditions three raw coin-sensor lines (1-, 2- and 5-unit slots): synchronise, debounce, detect insertion edges, reject ambiguous or overflow coins.
- Queues accepted coins in a small FIFO and presents them one at a time as a 3-bit money code with a valid/ready handshake.
- `money` reads 3'd0 whenever no coin is presented, so the FSM never sees a coin twice or a sensor glitch.

---
 rtl/coin_pkg.sv | 30 +++
 rtl/coin_debounce.sv | 54 +++++
 rtl/coin_acceptor.sv | 88 ++++++++
 3 files changed

// File: rtl/coin_pkg.sv
// Shared coin codes, sensor bit indices and output-state type for the coin front end.
package coin_pkg;

    localparam logic [2:0] COIN_NONE = 3'd0;
    localparam logic [2:0] COIN_1    = 3'd1;
    localparam logic [2:0] COIN_2    = 3'd2;
    localparam logic [2:0] COIN_5    = 3'd5;

    localparam int unsigned IDX_C1 = 0;
    localparam int unsigned IDX_C2 = 1;
    localparam int unsigned IDX_C5 = 2;

    typedef enum logic {EMPTY, PRESENT} out_state_e;

    // Map a one-hot insertion event to its money code.
    function automatic logic [2:0] ev_to_code(input logic [2:0] ev);
        logic [2:0] code;
        code = COIN_NONE;
        if (ev[IDX_C1])      code = COIN_1;
        else if (ev[IDX_C2]) code = COIN_2;
        else if (ev[IDX_C5]) code = COIN_5;
        return code;
    endfunction

    // True when two or more events fire together.
    function automatic logic multi_hot(input logic [2:0] ev);
        return (ev & (ev - 3'd1)) != 3'd0;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: two-flop synchroniser, debounce counter, rising-insertion strobe.
module coin_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic coin_i,
    output logic ev_o
);

    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q, s_q;
    logic       deb_q, deb_d;
    logic       seen_q;
    logic       ev_q;
    logic [3:0] cnt_q, cnt_d;

    // Debounced level only follows the synchronised input after CNT_MAX+1 steady mismatches.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (s_q == deb_q) begin
            cnt_d = 4'd0;
        end else if (cnt_q == CNT_MAX) begin
            deb_d = s_q;
            cnt_d = 4'd0;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Sync, debounce state, and a one-cycle strobe registered off the settled level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= 4'd0;
            seen_q  <= 1'b0;
            ev_q    <= 1'b0;
        end else begin
            sync1_q <= coin_i;
            s_q     <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            seen_q  <= deb_q;
            ev_q    <= deb_q & ~seen_q;
        end
    end

    assign ev_o = ev_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: debounces three sensors, arbitrates insertions, queues codes in a FIFO
// and presents them to the vending FSM with a valid/ready handshake.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] coin_in,
    output logic [2:0] money,
    output logic       money_valid,
    input  logic       money_ready,
    output logic       reject,
    output logic       fifo_full
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [2:0]    ev;
    logic          single, multi, pop, push, reject_d;
    logic [2:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          reject_q;
    out_state_e    state_q, state_d;

    for (genvar i = 0; i < 3; i++) begin : g_deb
        coin_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .coin_i (coin_in[i]),
            .ev_o   (ev[i])
        );
    end

    assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
    assign money_valid = (state_q == PRESENT);
    assign money       = money_valid ? mem_q[rd_ptr_q] : COIN_NONE;
    assign reject      = reject_q;

    // Arbitration: a lone event is queued; simultaneous events or a full FIFO without a pop
    // send the coin back.
    always_comb begin
        multi    = multi_hot(ev);
        single   = (ev != 3'd0) && !multi;
        pop      = money_valid && money_ready;
        push     = single && (!fifo_full || pop);
        reject_d = multi || (single && fifo_full && !pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Output state tracks whether a head entry is being presented.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (push) state_d = PRESENT;
            PRESENT: if (pop && !push && count_q == CW'(1)) state_d = EMPTY;
        endcase
    end

    // FIFO pointers, occupancy, output state and reject pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= EMPTY;
            reject_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            count_q  <= count_d;
            state_q  <= state_d;
            reject_q <= reject_d;
        end
    end

    // Storage needs no reset: entries are only read behind a valid occupancy.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ev_to_code(ev);
    end

endmodule
